// File: rtl/pll_freq_monitor.sv
// pll_freq_monitor: counts rising edges of the divided PLL feedback (meas_in) over fixed clkin windows
// and reports locked/fault status. Define FMON_MINMAX_EN to add the count_min/count_max outputs.
module pll_freq_monitor #(
    parameter int WINDOW_CYCLES = 2700,
    parameter int EXPECT        = 304,
    parameter int TOL           = 2,
    parameter int LOCK_WINDOWS  = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             enable,
    input  logic             meas_in,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             locked,
    output logic             fault
`ifdef FMON_MINMAX_EN
    ,
    output logic [CNT_W-1:0] count_min,
    output logic [CNT_W-1:0] count_max
`endif
);

    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam int GR_W  = $clog2(LOCK_WINDOWS + 1);

    localparam logic [WIN_W-1:0] L_WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [GR_W-1:0]  L_LOCK     = GR_W'(LOCK_WINDOWS);
    localparam logic [CNT_W:0]   L_EXPECT   = (CNT_W+1)'(EXPECT);
    localparam logic [CNT_W:0]   L_TOL      = (CNT_W+1)'(TOL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_EVAL
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic             r_meas_s1;
    logic             r_meas_s2;
    logic             r_meas_prev;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_count_valid;
    logic             r_locked;
    logic             r_fault;
    logic [GR_W-1:0]  r_good_run;

    logic             w_edge;
    logic             w_measure;
    logic             w_eval;
    logic             w_good;
    logic [CNT_W-1:0] w_edge_sum;
    logic [CNT_W:0]   w_cnt_ext;
    logic [GR_W-1:0]  w_good_run_inc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_next_state = ST_MEASURE;
                ST_MEASURE: if (r_win_cnt == L_WIN_LAST) w_next_state = ST_EVAL;
                ST_EVAL:    w_next_state = ST_MEASURE;
                default:    w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_measure = 1'b0;
        w_eval    = 1'b0;
        if (enable) begin
            w_measure = (r_state == ST_MEASURE);
            w_eval    = (r_state == ST_EVAL);
        end
    end

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_meas_s1   <= 1'b0;
            r_meas_s2   <= 1'b0;
            r_meas_prev <= 1'b0;
        end else begin
            r_meas_s1   <= meas_in;
            r_meas_s2   <= r_meas_s1;
            r_meas_prev <= r_meas_s2;
        end
    end

    assign w_edge     = r_meas_s2 & ~r_meas_prev;
    assign w_edge_sum = (r_edge_cnt == '1) ? r_edge_cnt : r_edge_cnt + CNT_W'(w_edge);

    // The EVAL-cycle edge seeds the next window so no edge is lost or counted twice.
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
        end else if (w_measure) begin
            r_win_cnt  <= r_win_cnt + 1'b1;
            r_edge_cnt <= w_edge_sum;
        end else if (w_eval) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= CNT_W'(w_edge);
        end else begin
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
        end
    end

    assign w_cnt_ext      = {1'b0, r_edge_cnt};
    assign w_good         = (w_cnt_ext + L_TOL >= L_EXPECT) && (w_cnt_ext <= L_EXPECT + L_TOL);
    assign w_good_run_inc = (r_good_run == L_LOCK) ? r_good_run : r_good_run + 1'b1;

    always_ff @(posedge clkin) begin
        if (reset || !enable) begin
            r_count_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_fault       <= 1'b0;
            r_good_run    <= '0;
            if (reset) begin
                r_count <= '0;
            end
        end else begin
            r_count_valid <= w_eval;
            if (w_eval) begin
                r_count <= r_edge_cnt;
                if (w_good) begin
                    r_good_run <= w_good_run_inc;
                    r_locked   <= (w_good_run_inc == L_LOCK);
                end else begin
                    r_good_run <= '0;
                    r_locked   <= 1'b0;
                    if (r_locked) begin
                        r_fault <= 1'b1;
                    end
                end
            end
        end
    end

    assign count       = r_count;
    assign count_valid = r_count_valid;
    assign locked      = r_locked;
    assign fault       = r_fault;

`ifdef FMON_MINMAX_EN
    logic [CNT_W-1:0] r_count_min;
    logic [CNT_W-1:0] r_count_max;
    logic             w_mm_clear;

    // Starting from all-ones/zero lets the first window set both extremes without a flag.
    assign w_mm_clear = reset || !enable || (r_state == ST_IDLE);

    always_ff @(posedge clkin) begin
        if (w_mm_clear) begin
            r_count_min <= '1;
            r_count_max <= '0;
        end else if (w_eval) begin
            if (r_edge_cnt < r_count_min) r_count_min <= r_edge_cnt;
            if (r_edge_cnt > r_count_max) r_count_max <= r_edge_cnt;
        end
    end

    assign count_min = r_count_min;
    assign count_max = r_count_max;
`endif

endmodule
